cache_fill_fsm: RTL and testbench

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_fill_if.sv | 30 +++
 rtl/cache_fill_fsm.sv | 94 +++++++++
 tb/tb_cache_fill_fsm.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_if.sv
// Handshake bundle between the tag-compare / memory side and the cache fill FSM.
// The master drives miss requests and memory returns; the slave is the fill FSM.
interface cache_fill_if #(
  parameter int DATA_W = 16
);
  logic              miss_detected;
  logic [15:0]       miss_address;
  logic [DATA_W-1:0] memory_data;
  logic              memory_data_valid;
  logic              memory_read;
  logic [15:0]       memory_address;
  logic              fsm_busy;
  logic              write_data_array;
  logic [2:0]        word_sel;
  logic [1:0]        set_sel;
  logic [DATA_W-1:0] data_out;
  logic              write_tag_array;

  modport master (
    output miss_detected, miss_address, memory_data, memory_data_valid,
    input  memory_read, memory_address, fsm_busy, write_data_array,
           word_sel, set_sel, data_out, write_tag_array
  );

  modport slave (
    input  miss_detected, miss_address, memory_data, memory_data_valid,
    output memory_read, memory_address, fsm_busy, write_data_array,
           word_sel, set_sel, data_out, write_tag_array
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache block fill controller: on a miss, streams 8 back-to-back word reads to
// memory and writes the in-order responses into the data array, then the tag.
module cache_fill_fsm #(
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8
) (
  input logic         clk,
  input logic         rst,
  cache_fill_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  localparam logic [3:0] REQ_DONE  = 4'(BLOCK_WORDS);
  localparam logic [2:0] LAST_WORD = 3'(BLOCK_WORDS - 1);

  logic [0:0]  state;
  logic [3:0]  req_cnt;
  logic [2:0]  rcv_cnt;
  logic [15:0] base_addr;

  logic issue;
  logic accept;
  logic last_word;

  // Requests and responses are independent streams; only valid pulses are counted.
  assign issue     = (state == FILL) && (req_cnt != REQ_DONE);
  assign accept    = (state == FILL) && bus.memory_data_valid;
  assign last_word = accept && (rcv_cnt == LAST_WORD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_cnt   <= 4'd0;
      rcv_cnt   <= 3'd0;
      base_addr <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (bus.miss_detected) begin
            state     <= FILL;
            base_addr <= bus.miss_address & 16'hFFF0;
            req_cnt   <= 4'd0;
            rcv_cnt   <= 3'd0;
          end
        end
        FILL: begin
          if (issue) begin
            req_cnt <= req_cnt + 4'd1;
          end
          if (accept) begin
            rcv_cnt <= rcv_cnt + 3'd1;
          end
          // Final response wins over any in-flight counter update.
          if (last_word) begin
            state   <= IDLE;
            req_cnt <= 4'd0;
            rcv_cnt <= 3'd0;
          end
        end
        default: begin
          state   <= IDLE;
          req_cnt <= 4'd0;
          rcv_cnt <= 3'd0;
        end
      endcase
    end
  end

  // base_addr[3:0] is always zero, so the word offset never carries into [15:4].
  always_comb begin
    bus.memory_read      = 1'b0;
    bus.memory_address   = 16'h0000;
    bus.write_data_array = 1'b0;
    bus.word_sel         = 3'b000;
    bus.data_out         = '0;
    bus.write_tag_array  = 1'b0;
    if (issue) begin
      bus.memory_read    = 1'b1;
      bus.memory_address = base_addr + {12'h000, req_cnt[2:0], 1'b0};
    end
    if (accept) begin
      bus.write_data_array = 1'b1;
      bus.word_sel         = rcv_cnt;
      bus.data_out         = bus.memory_data;
      bus.write_tag_array  = last_word;
    end
  end

  assign bus.fsm_busy = (state == FILL);
  assign bus.set_sel  = base_addr[5:4];

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomized bench for cache_fill_fsm: an in-order memory model with random latency
// feeds the DUT, and a block-level fill model predicts every output each cycle.
module tb_cache_fill_fsm;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_fill_if #(.DATA_W(DATA_W)) bus ();

  cache_fill_fsm #(.DATA_W(DATA_W), .BLOCK_WORDS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: whether a block fill is open, its block address, how many
  // word requests have gone out and how many responses have come back.
  bit          m_busy = 1'b0;
  logic [15:0] m_base = 16'h0000;
  int          m_nreq = 0;
  int          m_nrcv = 0;

  typedef struct {
    int          due;
    int          idx;
    logic [15:0] data;
  } resp_t;
  resp_t pend[$];

  int cyc = 0;
  int last_due = 0;
  int lat_cfg = 1;
  int gap_cfg = 1;
  bit fixed_data = 1'b0;

  int          wr_seen, tag_seen, busy_seen;
  logic [15:0] last_addr_seen;
  logic [1:0]  set_seen;

  task automatic step();
    bit          exp_read, exp_wr, exp_tag, delivered;
    logic [15:0] exp_addr, exp_dout;
    logic [2:0]  exp_ws;
    int          idx, due;
    resp_t       r;

    delivered = 1'b0;
    idx = 0;
    bus.memory_data_valid = 1'b0;
    bus.memory_data = 16'($urandom);
    if (pend.size() > 0 && pend[0].due == cyc) begin
      delivered = 1'b1;
      idx = pend[0].idx;
      bus.memory_data_valid = 1'b1;
      bus.memory_data = pend[0].data;
    end

    @(negedge clk);
    exp_read = m_busy && (m_nreq < 8);
    exp_addr = exp_read ? 16'(int'(m_base) + 2 * m_nreq) : 16'h0000;
    exp_wr   = m_busy && delivered;
    exp_ws   = exp_wr ? 3'(idx) : 3'd0;
    exp_dout = exp_wr ? bus.memory_data : 16'h0000;
    exp_tag  = exp_wr && (idx == 7);

    check("memory_read", bus.memory_read, exp_read);
    check("memory_address", bus.memory_address, exp_addr);
    check("fsm_busy", bus.fsm_busy, m_busy);
    check("write_data_array", bus.write_data_array, exp_wr);
    check("word_sel", bus.word_sel, exp_ws);
    check("data_out", bus.data_out, exp_dout);
    check("write_tag_array", bus.write_tag_array, exp_tag);
    check("set_sel", bus.set_sel, m_base[5:4]);

    if (bus.write_data_array) wr_seen++;
    if (bus.write_tag_array) tag_seen++;
    if (bus.fsm_busy) begin
      busy_seen++;
      set_seen = bus.set_sel;
    end
    if (bus.memory_read) last_addr_seen = bus.memory_address;

    if (delivered) void'(pend.pop_front());
    if (exp_read) begin
      due = cyc + lat_cfg;
      if (last_due + gap_cfg > due) due = last_due + gap_cfg;
      r.due  = due;
      r.idx  = m_nreq;
      r.data = fixed_data ? 16'hA000 + 16'(m_nreq) : 16'($urandom);
      pend.push_back(r);
      last_due = due;
    end

    if (rst) begin
      m_busy = 1'b0; m_base = 16'h0000; m_nreq = 0; m_nrcv = 0;
    end else if (m_busy) begin
      if (exp_read) m_nreq++;
      if (exp_wr) begin
        m_nrcv++;
        if (m_nrcv == 8) begin
          m_busy = 1'b0; m_nreq = 0; m_nrcv = 0;
        end
      end
    end else if (bus.miss_detected) begin
      m_busy = 1'b1; m_base = bus.miss_address & 16'hFFF0; m_nreq = 0; m_nrcv = 0;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_fill(input logic [15:0] addr, input int lat, input int gap,
                          input bit hold, input bit change_addr);
    int n;
    lat_cfg = lat;
    gap_cfg = gap;
    wr_seen = 0; tag_seen = 0; busy_seen = 0;
    bus.miss_detected = 1'b1;
    bus.miss_address  = addr;
    step();
    n = 0;
    while (m_busy && n < 300) begin
      bus.miss_detected = hold;
      if (change_addr && n == 5) bus.miss_address = 16'h5550;
      step();
      n++;
    end
    check("fill_completes", 32'(n < 300), 32'd1);
    check("fill_write_count", wr_seen, 8);
    check("fill_tag_count", tag_seen, 1);
  endtask

  task automatic idle(input int n);
    bus.miss_detected = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n;
    bus.miss_detected = 1'b0;
    bus.miss_address = 16'h0000;
    bus.memory_data = 16'h0000;
    bus.memory_data_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.fsm_busy, 1'b0);
    check("rst_read", bus.memory_read, 1'b0);
    check("rst_addr", bus.memory_address, 16'h0000);
    check("rst_wr", bus.write_data_array, 1'b0);
    check("rst_set", bus.set_sel, 2'b00);
    rst = 1'b0;
    idle(2);

    // Reference fill: latency 4, data A000+i, 12 busy cycles, set 3.
    fixed_data = 1'b1;
    run_fill(16'h1236, 4, 1, 1'b0, 1'b0);
    check("ref_busy_cycles", busy_seen, 12);
    check("ref_set_sel", set_seen, 2'b11);
    check("ref_last_addr", last_addr_seen, 16'h123E);
    fixed_data = 1'b0;
    idle(3);

    run_fill(16'h0A5C, 1, 1, 1'b0, 1'b0);
    idle(2);
    run_fill(16'h7710, 1, 3, 1'b0, 1'b0);
    idle(2);

    // Miss held through the fill with a new address; next fill follows one IDLE cycle.
    run_fill(16'h0040, 2, 1, 1'b1, 1'b1);
    run_fill(16'h5550, 3, 2, 1'b0, 1'b0);
    check("refill_last_addr", last_addr_seen, 16'h555E);
    idle(2);

    run_fill(16'hFFFF, 2, 1, 1'b0, 1'b0);
    check("top_last_addr", last_addr_seen, 16'hFFFE);
    idle(2);

    // Abort a fill with reset after its third write.
    lat_cfg = 3; gap_cfg = 3;
    wr_seen = 0; tag_seen = 0;
    bus.miss_detected = 1'b1;
    bus.miss_address = 16'h2468;
    step();
    bus.miss_detected = 1'b0;
    n = 0;
    while (wr_seen < 3 && n < 100) begin
      step();
      n++;
    end
    check("abort_reached_third", 32'(n < 100), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", bus.fsm_busy, 1'b0);
    check("abort_read", bus.memory_read, 1'b0);
    check("abort_wr", bus.write_data_array, 1'b0);
    check("abort_tag", bus.write_tag_array, 1'b0);
    check("abort_set", bus.set_sel, 2'b00);
    idle(40);
    check("abort_write_count", wr_seen, 3);
    check("abort_tag_count", tag_seen, 0);
    check("abort_drained", pend.size(), 0);

    for (int k = 0; k < 8; k++) begin
      run_fill(16'($urandom), int'($urandom_range(1, 6)), int'($urandom_range(1, 3)),
               1'($urandom_range(0, 1)), 1'b0);
      idle(int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
